// File: rtl/alu_issue.sv
// Decode / operand-issue stage in front of the 16-bit ALU.
// Accepts instructions on a valid/ready handshake, reads an 8-entry register
// file, tracks outstanding destinations in a per-register scoreboard and
// drives registered operands to the ALU. Results return on the writeback port.
// Optional feature: define ALU_ISSUE_BYPASS_EN to forward same-cycle writeback
// data into the operands and drop the returning register from the stall check.
module alu_issue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  input  logic [15:0]       instr_i,
  output logic              instr_ready_o,
  output logic              issue_valid_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_op_o,
  output logic [2:0]        issue_rd_o,
  input  logic              wb_en_i,
  input  logic [2:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i
);

  localparam logic [2:0] OpNop = 3'b111;

  // Instruction fields
  logic [2:0]       op, rd, rs, rt;
  logic             imm_sel;
  logic [IMM_W-1:0] imm;

  assign op      = instr_i[15:13];
  assign rd      = instr_i[12:10];
  assign rs      = instr_i[9:7];
  assign rt      = instr_i[6:4];
  assign imm_sel = instr_i[3];
  assign imm     = instr_i[IMM_W-1:0];

  // State
  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];
  logic [7:0]        pending_q, pending_d;
  logic              issue_valid_q, issue_valid_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [2:0]        issue_rd_q, issue_rd_d;

  // Writeback to R0 is ignored entirely, so it never touches storage or pending.
  logic       wb_hit;
  logic [7:0] wb_mask;
  logic [7:0] pend_eff;
  logic       stall;
  logic       accept;
  logic       issue;
  logic [DATA_W-1:0] src_s, src_t, op_b;

  assign wb_hit  = wb_en_i && (wb_rd_i != 3'd0);
  assign wb_mask = wb_hit ? (8'b1 << wb_rd_i) : 8'b0;

`ifdef ALU_ISSUE_BYPASS_EN
  // A result arriving this cycle no longer blocks its consumers.
  assign pend_eff = pending_q & ~wb_mask;
`else
  assign pend_eff = pending_q;
`endif

  // Hazard check: RAW on sources (rt only when used), WAW on a real destination.
  assign stall = pend_eff[rs]
               | (!imm_sel && pend_eff[rt])
               | ((rd != 3'd0) && pend_eff[rd]);

  assign instr_ready_o = !stall && rst_n;
  assign accept        = instr_valid_i && instr_ready_o;
  assign issue         = accept && (op != OpNop);

  // Operand read: pre-edge register contents, R0 hardwired to zero.
  always_comb begin
    src_s = (rs == 3'd0) ? '0 : rf_q[rs];
    src_t = (rt == 3'd0) ? '0 : rf_q[rt];
`ifdef ALU_ISSUE_BYPASS_EN
    if (wb_hit && (wb_rd_i == rs)) src_s = wb_data_i;
    if (wb_hit && (wb_rd_i == rt)) src_t = wb_data_i;
`endif
    op_b = imm_sel ? {{(DATA_W-IMM_W){1'b0}}, imm} : src_t;
  end

  // Register file next state: writeback only.
  always_comb begin
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_rd_i] = wb_data_i;
  end

  // Scoreboard next state: clear on writeback, then set on issue so set wins.
  always_comb begin
    pending_d = pending_q & ~wb_mask;
    if (issue && (rd != 3'd0)) pending_d[rd] = 1'b1;
  end

  // Issue outputs: pulse valid for one cycle per issue, otherwise hold operands.
  always_comb begin
    issue_valid_d = 1'b0;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    issue_rd_d    = issue_rd_q;
    if (issue) begin
      issue_valid_d = 1'b1;
      alu_a_d       = src_s;
      alu_b_d       = op_b;
      alu_op_d      = op;
      issue_rd_d    = rd;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      pending_q     <= '0;
      issue_valid_q <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= 3'b000;
      issue_rd_q    <= 3'd0;
    end else begin
      rf_q          <= rf_d;
      pending_q     <= pending_d;
      issue_valid_q <= issue_valid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      issue_rd_q    <= issue_rd_d;
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_op_o      = alu_op_q;
  assign issue_rd_o    = issue_rd_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a randomized run
// against a behavioural model of the register file, scoreboard and issue port.
module tb_alu_issue;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        issue_valid;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op, issue_rd;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_rd = '0;
  logic [15:0] wb_data = '0;

  alu_issue #(.DATA_W(16), .IMM_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid_i(instr_valid),
    .instr_i      (instr),
    .instr_ready_o(instr_ready),
    .issue_valid_o(issue_valid),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .issue_rd_o   (issue_rd),
    .wb_en_i      (wb_en),
    .wb_rd_i      (wb_rd),
    .wb_data_i    (wb_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_rf [8];
  bit          m_pend [8];
  logic        m_iv;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_op, m_rd;
  logic        m_acc;
  logic        exp_ready, obs_ready;

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int rt,
                                     input int isel, input int imm);
    logic [15:0] w;
    w = {op[2:0], rd[2:0], rs[2:0], rt[2:0], isel[0], imm[2:0]};
    return w;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_rf[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_iv = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
  endtask

  // A register blocks a reader unless it is R0 or (with forwarding) returning now.
  function automatic bit m_busy(input int r);
    if (r == 0) return 1'b0;
    if (Byp && wb_en && (int'(wb_rd) == r)) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic logic [15:0] m_read(input int r);
    if (r == 0) return 16'h0;
    if (Byp && wb_en && (int'(wb_rd) == r)) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic m_ready();
    int op, rd, rs, rt;
    bit isel;
    rd = int'(instr[12:10]); rs = int'(instr[9:7]); rt = int'(instr[6:4]); isel = instr[3];
    op = int'(instr[15:13]);
    if (!rst_n) return 1'b0;
    return !(m_busy(rs) || (!isel && m_busy(rt)) || m_busy(rd));
  endfunction

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic m_clock();
    int op, rd, rs, rt;
    logic [15:0] na, nb;
    op = int'(instr[15:13]); rd = int'(instr[12:10]);
    rs = int'(instr[9:7]);   rt = int'(instr[6:4]);
    m_acc = instr_valid && exp_ready;
    na = m_read(rs);
    nb = instr[3] ? {13'b0, instr[2:0]} : m_read(rt);
    if (wb_en) m_pend[wb_rd] = 1'b0;
    if (m_acc && op != 7) begin
      m_iv = 1'b1; m_a = na; m_b = nb; m_op = instr[15:13]; m_rd = instr[12:10];
      if (rd != 0) m_pend[rd] = 1'b1;
    end else begin
      m_iv = 1'b0;
    end
    if (wb_en && wb_rd != 3'd0) m_rf[wb_rd] = wb_data;
  endtask

  // Drive one cycle of stimulus; leaves time at posedge+1 with outputs settled.
  task automatic cycle(input logic v, input logic [15:0] ins, input logic we,
                       input logic [2:0] wr, input logic [15:0] wd);
    instr_valid = v; instr = ins; wb_en = we; wb_rd = wr; wb_data = wd;
    #1;
    exp_ready = m_ready();
    obs_ready = instr_ready;
    m_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0; instr_valid = 1'b0; wb_en = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if ({issue_valid, alu_a, alu_b, alu_op, issue_rd} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got iv=%b a=%h b=%h op=%h rd=%h want all zero",
               issue_valid, alu_a, alu_b, alu_op, issue_rd);
    end
    n_cmp++;
    if (instr_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", instr_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr = mk(0, 1, 2, 3, 0, 0);
    #1;
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: got %b want 1", instr_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    cycle(0, 16'h0, 1, 3'd1, 16'h0005);
    cycle(0, 16'h0, 1, 3'd2, 16'h0003);
    cycle(1, mk(0, 3, 1, 2, 0, 0), 0, 3'd0, 16'h0);
    n_cmp++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready: got %b want 1", obs_ready);
    end
    n_cmp++;
    if ({issue_valid, alu_a, alu_b, alu_op, issue_rd} !== {1'b1, 16'h5, 16'h3, 3'b000, 3'd3}) begin
      n_fail++;
      $display("FAIL basic_issue: got iv=%b a=%h b=%h op=%h rd=%h want 1 0005 0003 0 3",
               issue_valid, alu_a, alu_b, alu_op, issue_rd);
    end
    cycle(0, mk(0, 5, 3, 0, 1, 0), 0, 3'd0, 16'h0);
    n_cmp++;
    if (obs_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_pend3: got ready %b want 0", obs_ready);
    end
    n_cmp++;
    if ({issue_valid, alu_a} !== {1'b0, 16'h5}) begin
      n_fail++; $display("FAIL basic_hold: got iv=%b a=%h want 0 0005", issue_valid, alu_a);
    end
  endtask

  // Relies on pending[3] left by test_basic.
  task automatic test_raw();
    logic [15:0] ins;
    ins = mk(2, 5, 3, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, ins, 0, 3'd0, 16'h0);
      n_cmp++;
      if ({obs_ready, issue_valid} !== 2'b00) begin
        n_fail++; $display("FAIL raw_stall: got ready=%b iv=%b want 0 0", obs_ready, issue_valid);
      end
    end
    cycle(1, ins, 1, 3'd3, 16'h0008);
`ifdef ALU_ISSUE_BYPASS_EN
    n_cmp++;
    if ({obs_ready, issue_valid, alu_a} !== {2'b11, 16'h0008}) begin
      n_fail++;
      $display("FAIL raw_bypass: got ready=%b iv=%b a=%h want 1 1 0008",
               obs_ready, issue_valid, alu_a);
    end
`else
    n_cmp++;
    if ({obs_ready, issue_valid} !== 2'b00) begin
      n_fail++; $display("FAIL raw_wbcycle: got ready=%b iv=%b want 0 0", obs_ready, issue_valid);
    end
    cycle(1, ins, 0, 3'd0, 16'h0);
    n_cmp++;
    if ({obs_ready, issue_valid, alu_a} !== {2'b11, 16'h0008}) begin
      n_fail++;
      $display("FAIL raw_after: got ready=%b iv=%b a=%h want 1 1 0008",
               obs_ready, issue_valid, alu_a);
    end
`endif
    cycle(0, 16'h0, 1, 3'd5, 16'h1234);
  endtask

  task automatic test_imm_r0();
    cycle(1, mk(1, 6, 0, 0, 1, 7), 0, 3'd0, 16'h0);
    n_cmp++;
    if ({issue_valid, alu_a, alu_b, alu_op, issue_rd} !== {1'b1, 16'h0, 16'h7, 3'b001, 3'd6}) begin
      n_fail++;
      $display("FAIL imm_issue: got iv=%b a=%h b=%h op=%h rd=%h want 1 0000 0007 1 6",
               issue_valid, alu_a, alu_b, alu_op, issue_rd);
    end
    cycle(0, 16'h0, 1, 3'd0, 16'hFFFF);
    cycle(1, mk(3, 0, 0, 0, 0, 0), 1, 3'd6, 16'h00AA);
    n_cmp++;
    if ({issue_valid, alu_a, alu_b, issue_rd} !== {1'b1, 16'h0, 16'h0, 3'd0}) begin
      n_fail++;
      $display("FAIL r0_read: got iv=%b a=%h b=%h rd=%h want 1 0000 0000 0",
               issue_valid, alu_a, alu_b, issue_rd);
    end
  endtask

  task automatic test_nop();
    cycle(1, mk(7, 2, 6, 6, 0, 0), 0, 3'd0, 16'h0);
    n_cmp++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL nop_ready: got %b want 1", obs_ready);
    end
    n_cmp++;
    if ({issue_valid, alu_a, alu_b, alu_op, issue_rd} !== {1'b0, 16'h0, 16'h0, 3'b011, 3'd0}) begin
      n_fail++;
      $display("FAIL nop_hold: got iv=%b a=%h b=%h op=%h rd=%h want 0 0000 0000 3 0",
               issue_valid, alu_a, alu_b, alu_op, issue_rd);
    end
    // rd=2 must still be free: the NOP set nothing.
    cycle(1, mk(4, 2, 6, 2, 0, 0), 0, 3'd0, 16'h0);
    n_cmp++;
    if ({obs_ready, issue_valid, alu_a, alu_b} !== {2'b11, 16'h00AA, 16'h0003}) begin
      n_fail++;
      $display("FAIL nop_nopend: got ready=%b iv=%b a=%h b=%h want 1 1 00aa 0003",
               obs_ready, issue_valid, alu_a, alu_b);
    end
    cycle(0, 16'h0, 1, 3'd2, 16'h0002);
  endtask

  task automatic test_waw();
    logic [15:0] ins;
    ins = mk(5, 4, 1, 1, 0, 0);
    cycle(1, ins, 0, 3'd0, 16'h0);
    n_cmp++;
    if ({issue_valid, issue_rd} !== {1'b1, 3'd4}) begin
      n_fail++; $display("FAIL waw_first: got iv=%b rd=%h want 1 4", issue_valid, issue_rd);
    end
    cycle(1, ins, 0, 3'd0, 16'h0);
    n_cmp++;
    if ({obs_ready, issue_valid} !== 2'b00) begin
      n_fail++; $display("FAIL waw_stall: got ready=%b iv=%b want 0 0", obs_ready, issue_valid);
    end
    cycle(1, ins, 1, 3'd4, 16'h0077);
`ifdef ALU_ISSUE_BYPASS_EN
    n_cmp++;
    if ({obs_ready, issue_valid, issue_rd} !== {2'b11, 3'd4}) begin
      n_fail++; $display("FAIL waw_bypass: got ready=%b iv=%b want 1 1", obs_ready, issue_valid);
    end
`else
    n_cmp++;
    if ({obs_ready, issue_valid} !== 2'b00) begin
      n_fail++; $display("FAIL waw_wbcycle: got ready=%b iv=%b want 0 0", obs_ready, issue_valid);
    end
    cycle(1, ins, 0, 3'd0, 16'h0);
    n_cmp++;
    if ({obs_ready, issue_valid, issue_rd} !== {2'b11, 3'd4}) begin
      n_fail++; $display("FAIL waw_after: got ready=%b iv=%b want 1 1", obs_ready, issue_valid);
    end
`endif
    cycle(0, 16'h0, 1, 3'd4, 16'h0044);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      cycle(1, mk(i, i + 1, 7, 6, 0, 0), 0, 3'd0, 16'h0);
      n_cmp++;
      if ({issue_valid, alu_op, issue_rd} !== {1'b1, 3'(i), 3'(i + 1)}) begin
        n_fail++;
        $display("FAIL b2b_%0d: got iv=%b op=%h rd=%h want 1 %0d %0d",
                 i, issue_valid, alu_op, issue_rd, i, i + 1);
      end
    end
    for (int r = 1; r <= 4; r++) cycle(0, 16'h0, 1, 3'(r), 16'(r * 16'h0101));
  endtask

  task automatic test_random();
    int inflight [$];
    logic v, we;
    logic [15:0] ins, wd;
    logic [2:0] wr;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        test_reset();
        inflight.delete();
      end
      v = ($urandom_range(0, 3) != 0);
      ins = 16'($urandom);
      wd = 16'($urandom);
      we = 1'b0; wr = 3'd0;
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        we = 1'b1; wr = 3'(inflight.pop_front());
      end else if ($urandom_range(0, 15) == 0) begin
        we = 1'b1; wr = 3'($urandom);
      end
      cycle(v, ins, we, wr, wd);
      n_cmp++;
      if (obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
      end
      n_cmp++;
      if ({issue_valid, alu_a, alu_b, alu_op, issue_rd} !== {m_iv, m_a, m_b, m_op, m_rd}) begin
        n_fail++;
        $display("FAIL rnd_out[%0d]: got iv=%b a=%h b=%h op=%h rd=%h want %b %h %h %h %h", i,
                 issue_valid, alu_a, alu_b, alu_op, issue_rd, m_iv, m_a, m_b, m_op, m_rd);
      end
      if (m_acc && ins[15:13] != 3'b111 && ins[12:10] != 3'd0) inflight.push_back(int'(ins[12:10]));
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_raw();
    test_imm_r0();
    test_nop();
    test_waw();
    test_back_to_back();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
